// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - instruction fetch stage with prefetch queue driving IF/ID
// Optional macro IF_STALL_CNT_EN adds the stall_cnt output.
module if_prefetch_stage #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        if_valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, q_cnt_q, q_cnt_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d, q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic          req_hold_q, req_hold_d, valid_q, valid_d;
  logic [31:0]   instr_q, instr_d, pc_q, pc_d;
  logic [31:0]   tag_mem [FIFO_DEPTH];
  logic [31:0]   q_instr [FIFO_DEPTH];
  logic [31:0]   q_pc    [FIFO_DEPTH];
  logic          resp, drop, q_push, q_pop, grant;
  logic [CW:0]   credit_used;

  always_comb begin
    resp   = imem_rvalid && (out_cnt_q != '0);
    drop   = resp && (drop_cnt_q != '0);
    q_pop  = !branch_taken && !freeze && (q_cnt_q != '0);
    q_push = resp && !drop && !branch_taken;
    // The slot freed by this cycle's pop is reusable at once, giving one word per cycle with two credits.
    credit_used = {1'b0, out_cnt_q} + {1'b0, q_cnt_q} - {{CW{1'b0}}, q_pop};
    // A request that was raised but not yet granted is held so address and valid stay stable.
    imem_req  = rst && !branch_taken && (drop_cnt_q == '0) &&
                (req_hold_q || (credit_used < DEPTH_SUM));
    imem_addr = fetch_pc_q;
    grant     = imem_req && imem_gnt;

    fetch_pc_d = fetch_pc_q;
    if (branch_taken)  fetch_pc_d = branch_addr & 32'hFFFF_FFFC;
    else if (grant)    fetch_pc_d = fetch_pc_q + 32'd4;

    out_cnt_d  = out_cnt_q + CW'(grant) - CW'(resp);
    drop_cnt_d = drop_cnt_q;
    if (branch_taken) drop_cnt_d = out_cnt_q - CW'(resp);
    else if (drop)    drop_cnt_d = drop_cnt_q - CW'(1);
    req_hold_d = imem_req && !imem_gnt;
    tag_wr_d   = tag_wr_q + PW'(grant);
    tag_rd_d   = tag_rd_q + PW'(resp);

    if (branch_taken) begin
      q_wr_d  = '0;
      q_rd_d  = '0;
      q_cnt_d = '0;
    end else begin
      q_wr_d  = q_wr_q + PW'(q_push);
      q_rd_d  = q_rd_q + PW'(q_pop);
      q_cnt_d = q_cnt_q + CW'(q_push) - CW'(q_pop);
    end

    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (branch_taken) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!freeze) begin
      if (q_pop) begin
        instr_d = q_instr[q_rd_q];
        pc_d    = q_pc[q_rd_q];
        valid_d = 1'b1;
      end else begin
        instr_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      q_cnt_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      req_hold_q <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      q_cnt_q    <= q_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
      req_hold_q <= req_hold_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr_q] <= fetch_pc_q;
    if (q_push) begin
      q_instr[q_wr_q] <= imem_rdata;
      q_pc[q_wr_q]    <= tag_mem[tag_rd_q] + 32'd4;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign if_valid    = valid_q;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze || ((q_cnt_q == '0) && !branch_taken)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assert property (@(posedge clk) disable iff (!rst) !(q_push && (q_cnt_q == DEPTH_CNT)));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb/tb_if_prefetch_stage.sv - randomized self-checking bench for if_prefetch_stage
`timescale 1ns/1ps
module tb_if_prefetch_stage;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction, pc;
  logic        if_valid;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  if_prefetch_stage #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc           (pc),
    .if_valid     (if_valid)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: requests in flight (with a stale mark) and words waiting for decode.
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } word_t;
  req_t        m_out[$];
  word_t       m_q[$];
  logic [31:0] m_fetch, m_instr, m_pc, m_stall;
  bit          m_valid, m_held;

  // Memory: in-order responses, per-request latency, data = addr ^ mem_xor.
  logic [31:0] mem_addr_q[$];
  int          mem_ready_q[$];
  int          last_ready;
  logic [31:0] mem_xor = '0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  bit          inject_rvalid = 1'b0;
  int          cyc = 0, first_valid = -1;

  function automatic bit has_stale();
    foreach (m_out[i]) if (m_out[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_out.delete();
    m_q.delete();
    mem_addr_q.delete();
    mem_ready_q.delete();
    m_fetch = RST_PC;
    m_instr = '0;
    m_pc = '0;
    m_valid = 1'b0;
    m_held = 1'b0;
    m_stall = '0;
    last_ready = -1;
    cyc = 0;
    first_valid = -1;
  endtask

  // Called at a negedge; checks the registered outputs, drives one cycle, returns at next negedge.
  task automatic step(input bit frz, input bit br, input logic [31:0] ba);
    bit    pop, exp_req, grant, resp;
    int    used;
    word_t w_out, w_in;
    req_t  r;
    check("instruction", instruction, m_instr);
    check("pc", pc, m_pc);
    check("if_valid", 32'(if_valid), 32'(m_valid));
`ifdef IF_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    if (if_valid && first_valid < 0) first_valid = cyc;

    freeze = frz;
    branch_taken = br;
    branch_addr = ba;
    if (inject_rvalid) begin
      imem_rvalid = 1'b1;
      imem_rdata = $urandom;
    end else begin
      imem_rvalid = (mem_ready_q.size() > 0) && (mem_ready_q[0] <= cyc);
      imem_rdata = imem_rvalid ? (mem_addr_q[0] ^ mem_xor) : $urandom;
    end
    #1;

    pop = !br && !frz && (m_q.size() > 0);
    used = m_out.size() + m_q.size() - (pop ? 1 : 0);
    exp_req = !br && !has_stale() && (m_held || used < DEPTH);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (imem_req && exp_req) check("imem_addr", imem_addr, m_fetch);
    imem_gnt = ($urandom_range(99) < gnt_pct);
    grant = exp_req && imem_gnt;

    if (imem_rvalid && !inject_rvalid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_ready_q.pop_front());
    end
    if (imem_req && imem_gnt) begin
      int rdy;
      rdy = cyc + int'($urandom_range(lat_max, lat_min));
      if (rdy <= last_ready) rdy = last_ready + 1;
      last_ready = rdy;
      mem_addr_q.push_back(imem_addr);
      mem_ready_q.push_back(rdy);
    end

    if (frz || (m_q.size() == 0 && !br)) m_stall = m_stall + 32'd1;
    resp = imem_rvalid && (m_out.size() > 0);
    if (pop) w_out = m_q.pop_front();
    if (br) begin
      m_valid = 1'b0;
      m_instr = '0;
    end else if (!frz) begin
      if (pop) begin
        m_instr = w_out.instr;
        m_pc = w_out.pc;
        m_valid = 1'b1;
      end else begin
        m_instr = '0;
        m_valid = 1'b0;
      end
    end
    if (resp) begin
      r = m_out.pop_front();
      if (!r.stale && !br) begin
        w_in.instr = r.addr ^ mem_xor;
        w_in.pc = r.addr + 32'd4;
        m_q.push_back(w_in);
      end
    end
    if (br) begin
      m_q.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_fetch = {ba[31:2], 2'b00};
    end else if (grant) begin
      m_out.push_back('{m_fetch, 1'b0});
      m_fetch = m_fetch + 32'd4;
    end
    m_held = exp_req && !imem_gnt;
    inject_rvalid = 1'b0;

    @(negedge clk);
    cyc++;
  endtask

  // Asserts reset between edges, checks outputs clear immediately, releases on a negedge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_gnt = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    #1;
    check("rst_instruction", instruction, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    inject_rvalid = 1'b1;
  endtask

  initial begin
    do_reset();

    // Startup with single-cycle memory returning addr, freeze during cycles 6-8.
    for (int i = 0; i < 16; i++) step((i >= 6) && (i <= 8), 1'b0, 32'h0);
    check("first_valid_cycle", 32'(first_valid), 32'd3);

    // Branch with two 3-cycle requests outstanding; both stale responses must vanish.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && m_out.size() < 2; i++) step(1'b0, 1'b0, 32'h0);
    check("two_outstanding", 32'(m_out.size()), 32'd2);
    step(1'b0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 30 && !if_valid; i++) step(1'b0, 1'b0, 32'h0);
    check("branch_first_pc", pc, 32'h0000_0104);
    check("branch_first_instr", instruction, 32'h0000_0100);

    // Branch and freeze together: branch wins.
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);
    check("branch_freeze_valid", 32'(if_valid), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

    // Address wrap across 2^32.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);

    // Reset with two requests in flight; late rvalid after release must be ignored.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && m_out.size() < 2; i++) step(1'b0, 1'b0, 32'h0);
    check("two_outstanding_rst", 32'(m_out.size()), 32'd2);
    do_reset();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 12; i++) step((i >= 5) && (i <= 7), 1'b0, 32'h0);

    // Randomized traffic: variable grant, latency, freezes and branches.
    mem_xor = $urandom;
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 2000; i++) begin
      bit          frz, br;
      logic [31:0] ba;
      frz = ($urandom_range(99) < 20);
      br  = ($urandom_range(99) < 4);
      ba  = ($urandom_range(9) == 0) ? 32'hFFFF_FFF6 : $urandom;
      if (i == 1000) do_reset();
      step(frz, br, ba);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
